unidad_fetch: RTL and testbench

Instruction-fetch stage feeding the instruction memory and the IF/ID pipeline register.
- Holds the program counter and drives the 10-bit word address into the instruction memory, which has a synchronous one-cycle read.
- Pairs each returned instruction with its PC+1 and registers both into IF/ID.
- Honours stalls from the hazard detection unit and redirects from jump (ID) and branch (EX) resolution.
- Inserts bubbles when flushing.

---
 rtl/unidad_fetch.sv | 144 ++++++++++++++
 tb/tb_unidad_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_fetch.sv
// unidad_fetch - instruction-fetch stage.
//
// Holds the program counter, drives the word address into a synchronous
// (one-cycle read) instruction memory and registers each returned word with
// its PC+1 into the IF/ID pipeline register.  Honours hazard stalls, jump
// redirects from ID and taken-branch redirects from EX; any redirect flushes
// IF/ID with a single bubble.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous, active-low reset
//   stall           hold PC and IF/ID
//   branch_tomado   taken branch from EX (highest priority redirect)
//   branch_destino  branch target word address
//   jump            jump decoded in ID
//   jump_destino    jump target word address
//   direccion       address to instruction memory (next PC, combinational)
//   instruccion_in  word returned by instruction memory
//   instruccion_out IF/ID instruction
//   pc_mas1_out     IF/ID PC+1 of that instruction
//   valido_out      IF/ID holds a real instruction
//   detenido        fetch halted on an all-zero (HLT) word
//
// Optional feature: define FETCH_HLT_EN to halt fetch after an all-zero
// word; otherwise zero words flow as ordinary instructions and detenido is 0.
module unidad_fetch #(
    parameter int ANCHO_DIR   = 10,
    parameter int ANCHO_INSTR = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_tomado,
    input  logic [ANCHO_DIR-1:0]   branch_destino,
    input  logic                   jump,
    input  logic [ANCHO_DIR-1:0]   jump_destino,
    output logic [ANCHO_DIR-1:0]   direccion,
    input  logic [ANCHO_INSTR-1:0] instruccion_in,
    output logic [ANCHO_INSTR-1:0] instruccion_out,
    output logic [ANCHO_DIR-1:0]   pc_mas1_out,
    output logic                   valido_out,
    output logic                   detenido
);

    typedef enum logic [1:0] {
        ARRANQUE,
        CORRIENDO,
        DETENIDO
    } estado_t;

    estado_t                r_estado;
    logic [ANCHO_DIR-1:0]   r_pc;
    logic [ANCHO_INSTR-1:0] r_instr;
    logic [ANCHO_DIR-1:0]   r_pc_mas1;
    logic                   r_valido;

    logic [ANCHO_DIR-1:0]   w_pc_mas1;
    logic [ANCHO_DIR-1:0]   w_pc_sig;
    logic [ANCHO_DIR-1:0]   w_destino;
    logic                   w_redir;

    assign w_pc_mas1 = r_pc + ANCHO_DIR'(1);
    assign w_redir   = branch_tomado | jump;
    // Branch resolves later in the pipe than jump, so it wins.
    assign w_destino = branch_tomado ? branch_destino : jump_destino;

    // Next PC; the memory is addressed with it so memory and pc move together.
    always_comb begin
        w_pc_sig = '0;
        case (r_estado)
            ARRANQUE:  w_pc_sig = '0;
            CORRIENDO: begin
                if (w_redir)    w_pc_sig = w_destino;
                else if (stall) w_pc_sig = r_pc;
                else            w_pc_sig = w_pc_mas1;
            end
            default:   w_pc_sig = w_redir ? w_destino : r_pc;
        endcase
    end

    assign direccion       = w_pc_sig;
    assign instruccion_out = r_instr;
    assign pc_mas1_out     = r_pc_mas1;
    assign valido_out      = r_valido;

`ifdef FETCH_HLT_EN
    logic r_detenido;
    assign detenido = r_detenido;
`else
    assign detenido = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado   <= ARRANQUE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_pc_mas1  <= '0;
            r_valido   <= 1'b0;
`ifdef FETCH_HLT_EN
            r_detenido <= 1'b0;
`endif
        end else begin
            r_pc <= w_pc_sig;
            case (r_estado)
                ARRANQUE: begin
                    r_estado  <= CORRIENDO;
                    r_instr   <= '0;
                    r_pc_mas1 <= '0;
                    r_valido  <= 1'b0;
                end
                default: begin
                    if (w_redir) begin
                        // Flush: the word on the bus belongs to the wrong path.
                        r_estado   <= CORRIENDO;
                        r_instr    <= '0;
                        r_pc_mas1  <= '0;
                        r_valido   <= 1'b0;
`ifdef FETCH_HLT_EN
                        r_detenido <= 1'b0;
`endif
                    end else if (r_estado == CORRIENDO) begin
                        if (!stall) begin
                            r_instr   <= instruccion_in;
                            r_pc_mas1 <= w_pc_mas1;
                            r_valido  <= 1'b1;
`ifdef FETCH_HLT_EN
                            if (instruccion_in == '0) begin
                                r_estado   <= DETENIDO;
                                r_detenido <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        r_instr   <= '0;
                        r_pc_mas1 <= '0;
                        r_valido  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_fetch.sv
module tb_unidad_fetch;

    localparam int AW = 10;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          branch_tomado;
    logic [AW-1:0] branch_destino;
    logic          jump;
    logic [AW-1:0] jump_destino;
    logic [AW-1:0] direccion;
    logic [IW-1:0] instruccion_in;
    logic [IW-1:0] instruccion_out;
    logic [AW-1:0] pc_mas1_out;
    logic          valido_out;
    logic          detenido;

    int n_tests = 0;
    int n_fail  = 0;

    unidad_fetch #(.ANCHO_DIR(AW), .ANCHO_INSTR(IW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_tomado(branch_tomado), .branch_destino(branch_destino),
        .jump(jump), .jump_destino(jump_destino),
        .direccion(direccion), .instruccion_in(instruccion_in),
        .instruccion_out(instruccion_out), .pc_mas1_out(pc_mas1_out),
        .valido_out(valido_out), .detenido(detenido)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous one-cycle read.
    logic [IW-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) instruccion_in <= rom[direccion];

    // Reference model: address whose word is on the memory bus, fetch mode
    // (0 priming, 1 fetching, 2 halted) and the expected IF/ID contents.
    logic [AW-1:0] m_pc;
    int            m_mode;
    logic [IW-1:0] m_instr;
    logic [AW-1:0] m_pcm1;
    logic          m_v;
    logic          m_det;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_mode = 0; m_instr = '0; m_pcm1 = '0; m_v = 1'b0; m_det = 1'b0;
    endtask

    function automatic logic [AW-1:0] m_dir();
        if (m_mode == 0)                 return '0;
        if (branch_tomado)               return branch_destino;
        if (jump)                        return jump_destino;
        if (m_mode == 2 || stall)        return m_pc;
        return m_pc + AW'(1);
    endfunction

    task automatic bubble();
        m_instr = '0; m_pcm1 = '0; m_v = 1'b0;
    endtask

    task automatic model_edge();
        logic [AW-1:0] nxt;
        nxt = m_dir();
        if (m_mode == 0) begin
            m_mode = 1; bubble();
        end else if (branch_tomado || jump) begin
            m_mode = 1; m_det = 1'b0; bubble();
        end else if (m_mode == 1 && !stall) begin
            m_instr = rom[m_pc];
            m_pcm1  = m_pc + AW'(1);
            m_v     = 1'b1;
`ifdef FETCH_HLT_EN
            if (rom[m_pc] == '0) begin
                m_mode = 2; m_det = 1'b1;
            end
`endif
        end else if (m_mode == 2) begin
            bubble();
        end
        m_pc = nxt;
    endtask

    // Compare process: mid-cycle, inputs and outputs are settled.
    always @(negedge clk) begin
        chk("direccion", direccion, m_dir());
        chk("instruccion_out", instruccion_out, m_instr);
        chk("pc_mas1_out", pc_mas1_out, m_pcm1);
        chk("valido_out", valido_out, m_v);
        chk("detenido", detenido, m_det);
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drv(input logic st, input logic bt, input logic [AW-1:0] bd,
                       input logic j, input logic [AW-1:0] jd);
        stall = st; branch_tomado = bt; branch_destino = bd;
        jump = j; jump_destino = jd;
        #1;
    endtask

    task automatic ifid(input string name, input logic [IW-1:0] i, input logic [AW-1:0] p, input logic v);
        chk({name, ".instr"}, instruccion_out, i);
        chk({name, ".pcm1"}, pc_mas1_out, p);
        chk({name, ".valido"}, valido_out, v);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0; branch_tomado = 1'b0; branch_destino = '0;
        jump = 1'b0; jump_destino = '0;
        for (int i = 0; i < (1 << AW); i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        rom[0]    = 32'h00641020;
        rom[1]    = 32'h20620010;
        rom[2]    = 32'h8C220004;
        rom[3]    = 32'h00000C01;
        rom[32]   = 32'hAC450020;
        rom[1022] = 32'h10A00003;
        rom[1023] = 32'h08000000;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst.direccion", direccion, 0);
        ifid("rst", 0, 0, 0);
        chk("rst.detenido", detenido, 0);
        reset = 1'b1;
        #1 chk("arranque.direccion", direccion, 0);

        tick();
        chk("e1.valido", valido_out, 0);
        chk("e1.direccion", direccion, 1);
        tick();
        ifid("e2", 32'h00641020, 1, 1);
        chk("e2.direccion", direccion, 2);
        tick();
        ifid("e3", 32'h20620010, 2, 1);
        chk("e3.direccion", direccion, 3);

        // Stall two cycles while IF/ID holds rom[1].
        drv(1, 0, 0, 0, 0);
        chk("stall.direccion", direccion, 2);
        tick();
        ifid("stall1", 32'h20620010, 2, 1);
        chk("stall1.direccion", direccion, 2);
        tick();
        ifid("stall2", 32'h20620010, 2, 1);
        drv(0, 0, 0, 0, 0);
        tick();
        ifid("unstall", 32'h8C220004, 3, 1);
        tick();
        ifid("rom3", 32'h00000C01, 4, 1);

        // Jump to 0 while pc=4.
        drv(0, 0, 0, 1, 0);
        chk("jump.direccion", direccion, 0);
        tick();
        ifid("jump.bubble", 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        tick();
        ifid("jump.target", 32'h00641020, 1, 1);

        // Branch, jump and stall together: branch wins.
        drv(1, 1, 32, 1, 5);
        chk("bj.direccion", direccion, 32);
        tick();
        ifid("bj.bubble", 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        tick();
        ifid("bj.target", 32'hAC450020, 33, 1);

        // Fetch across the top of the address space.
        drv(0, 0, 0, 1, 1022);
        tick();
        drv(0, 0, 0, 0, 0);
        tick();
        ifid("w1022", 32'h10A00003, 1023, 1);
        chk("wrap.direccion", direccion, 0);
        tick();
        ifid("w1023", 32'h08000000, 0, 1);
        tick();
        ifid("w0", 32'h00641020, 1, 1);

        // Zero word at address 2 (not yet read by memory).
        rom[2] = 32'h0;
        tick();
        ifid("z1", 32'h20620010, 2, 1);
        tick();
        ifid("z2", 0, 3, 1);
`ifdef FETCH_HLT_EN
        chk("hlt.detenido", detenido, 1);
        tick();
        chk("hlt.valido", valido_out, 0);
        chk("hlt.detenido2", detenido, 1);
        drv(0, 1, 0, 0, 0);
        tick();
        chk("resume.detenido", detenido, 0);
        chk("resume.valido", valido_out, 0);
        drv(0, 0, 0, 0, 0);
        tick();
        ifid("resume", 32'h00641020, 1, 1);
`else
        chk("nohlt.detenido", detenido, 0);
        tick();
        ifid("nohlt", 32'h00000C01, 4, 1);
`endif

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b0;
        model_reset();
        #1;
        ifid("arst", 0, 0, 0);
        chk("arst.direccion", direccion, 0);
        chk("arst.detenido", detenido, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, AW'($urandom),
                $urandom_range(0, 9) == 0, AW'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
